// File: rtl/bp_bht_predictor_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared helpers for the branch-history-table predictor:
//   - idx_width(): table index width derived from the entry count
//   - ctr_max(), sat_inc(), sat_dec(): saturating counter arithmetic for
//     counters of run-time-selected width w (1..CTR_MAX_W)
//   - ctr_init(): weakly-not-taken initial counter value, 2^(w-1) - 1
// Counters are carried in a fixed CTR_MAX_W-bit container so one set of
// functions serves every CTR_W; callers cast back to their own width.
// -----------------------------------------------------------------------------
package bp_pkg;

    localparam int CTR_MAX_W = 4;

    typedef logic [CTR_MAX_W-1:0] ctr_t;

    // Index width for a power-of-two table; never below 1 so ports stay legal.
    function automatic int idx_width(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

    // All-ones value for a w-bit counter.
    function automatic ctr_t ctr_max(input int w);
        return ctr_t'((1 << w) - 1);
    endfunction

    function automatic ctr_t sat_inc(input ctr_t ctr, input int w);
        return (ctr >= ctr_max(w)) ? ctr : ctr + ctr_t'(1);
    endfunction

    function automatic ctr_t sat_dec(input ctr_t ctr, input int w);
        return (ctr == '0) ? ctr : ((ctr - ctr_t'(1)) & ctr_max(w));
    endfunction

    // Weakly not-taken: MSB clear, every lower bit set (01 for 2 bits, 0 for 1).
    function automatic ctr_t ctr_init(input int w);
        return ctr_t'((1 << (w - 1)) - 1);
    endfunction

endpackage

// File: rtl/bp_perf_counter.sv
// -----------------------------------------------------------------------------
// bp_perf_counter
// 32-bit saturating event counter. Counts one per cycle with inc_i high and
// sticks at 32'hFFFF_FFFF instead of wrapping. Reset is synchronous and wins
// over a same-cycle increment.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset (count -> RST_VAL)
//   inc_i    count one event this cycle
//   count_o  current count
// -----------------------------------------------------------------------------
module bp_perf_counter #(
    // Value loaded by reset; zero in normal use.
    parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    output logic [31:0] count_o
);

    logic [31:0] count_reg;
    logic [31:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (inc_i && (count_reg != 32'hFFFF_FFFF)) begin
            count_next = count_reg + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_reg <= RST_VAL;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count_o = count_reg;

endmodule

// File: rtl/bp_bht_predictor.sv
// -----------------------------------------------------------------------------
// bp_bht_predictor
// Branch history table of ENTRIES saturating CTR_W-bit counters. Indexed by
// PC[IDX_W+1:2] (bimodal, GHR_W = 0) or PC[IDX_W+1:2] XOR global history
// (gshare, GHR_W = 1..IDX_W). Prediction is combinational for use in ID;
// training, history and perf counters update on the edge where update_i = 1.
// Ports:
//   clk_i             clock
//   rst_i             synchronous active-high reset
//   lookup_valid_i    ID holds a branch to predict
//   lookup_pc_i       PC of the branch in ID
//   predict_o         predicted taken (0 when no lookup)
//   predict_idx_o     table index used; carried down the pipe for the update
//   update_i          a branch resolved in EX this cycle
//   update_idx_i      index captured at lookup time
//   update_pred_i     prediction made for the resolving branch
//   result_i          actual outcome (1 = taken)
//   branch_cnt_o      branches resolved (saturating)
//   mispredict_cnt_o  mispredictions (saturating)
// -----------------------------------------------------------------------------
module bp_bht_predictor
    import bp_pkg::*;
#(
    parameter  int ENTRIES = 64,
    parameter  int CTR_W   = 2,
    parameter  int GHR_W   = 0,
    localparam int IDX_W   = idx_width(ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             lookup_valid_i,
    input  logic [31:0]      lookup_pc_i,
    output logic             predict_o,
    output logic [IDX_W-1:0] predict_idx_o,
    input  logic             update_i,
    input  logic [IDX_W-1:0] update_idx_i,
    input  logic             update_pred_i,
    input  logic             result_i,
    output logic [31:0]      branch_cnt_o,
    output logic [31:0]      mispredict_cnt_o
);

    // ------------------------------------------------------------------
    // Global history (only exists in gshare mode)
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] hist_term;

    generate
        if (GHR_W > 0) begin : g_gshare
            logic [GHR_W-1:0] ghr_reg;
            logic [GHR_W-1:0] ghr_next;

            // Newest outcome enters at bit 0; written as shift-then-insert so
            // a one-bit history needs no special case.
            always_comb begin
                ghr_next    = ghr_reg << 1;
                ghr_next[0] = result_i;
            end

            // History is trained only at resolution, never speculatively.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    ghr_reg <= '0;
                end else if (update_i) begin
                    ghr_reg <= ghr_next;
                end
            end

            assign hist_term = IDX_W'(ghr_reg);
        end else begin : g_bimodal
            assign hist_term = '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Lookup index
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] lookup_idx;
    logic             unused_pc_bits;

    assign lookup_idx     = lookup_pc_i[IDX_W+1:2] ^ hist_term;
    // Instruction-alignment bits and PC bits above the index never matter.
    assign unused_pc_bits = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0]};

    // ------------------------------------------------------------------
    // Counter table: flops, so reset can restore every entry in one edge.
    // Each entry owns its register; table_rd is the read view of all of them.
    // ------------------------------------------------------------------
    logic [CTR_W-1:0] table_rd [ENTRIES];
    logic [CTR_W-1:0] upd_ctr;
    logic [CTR_W-1:0] upd_ctr_next;

    assign upd_ctr = table_rd[update_idx_i];

    always_comb begin
        upd_ctr_next = upd_ctr;
        if (result_i) begin
            upd_ctr_next = CTR_W'(sat_inc(ctr_t'(upd_ctr), CTR_W));
        end else begin
            upd_ctr_next = CTR_W'(sat_dec(ctr_t'(upd_ctr), CTR_W));
        end
    end

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic [CTR_W-1:0] ctr_reg;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    ctr_reg <= CTR_W'(ctr_init(CTR_W));
                end else if (update_i && (update_idx_i == IDX_W'(gi))) begin
                    ctr_reg <= upd_ctr_next;
                end
            end

            assign table_rd[gi] = ctr_reg;
        end
    endgenerate

    // Reads the registered counter, so a same-cycle update to the same
    // entry is not visible until the next cycle (no bypass).
    assign predict_o     = lookup_valid_i & table_rd[lookup_idx][CTR_W-1];
    assign predict_idx_o = lookup_idx;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic mispredict_evt;

    assign mispredict_evt = update_i & (update_pred_i ^ result_i);

    bp_perf_counter u_branch_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (update_i),
        .count_o (branch_cnt_o)
    );

    bp_perf_counter u_mispredict_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (mispredict_evt),
        .count_o (mispredict_cnt_o)
    );

endmodule

// File: tb/tb_bp_bht_predictor.sv
// -----------------------------------------------------------------------------
// tb_bp_bht_predictor
// Two predictors share one stimulus stream: a bimodal one (GHR_W = 0) and a
// gshare one (GHR_W = 4), both ENTRIES = 64, CTR_W = 2. The driver computes
// the expected outputs of both from a behavioural model and queues them; a
// monitor on the falling edge pops and compares. A standalone perf counter
// preloaded near the top checks saturation at 32'hFFFF_FFFF.
// -----------------------------------------------------------------------------
module tb_bp_bht_predictor;

    localparam int ENTRIES = 64;
    localparam int IDX_W   = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst   = 1'b1;
    logic             lv    = 1'b0;
    logic [31:0]      pc    = 32'h0;
    logic             upd   = 1'b0;
    logic [IDX_W-1:0] uidx  = '0;
    logic             upred = 1'b0;
    logic             res   = 1'b0;

    logic             p0, p1;
    logic [IDX_W-1:0] i0, i1;
    logic [31:0]      b0, m0, b1, m1;

    logic             sat_rst = 1'b1;
    logic             sat_inc = 1'b0;
    logic [31:0]      sat_cnt;

    bp_bht_predictor #(.ENTRIES(ENTRIES), .CTR_W(2), .GHR_W(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .lookup_valid_i(lv), .lookup_pc_i(pc),
        .predict_o(p0), .predict_idx_o(i0), .update_i(upd), .update_idx_i(uidx),
        .update_pred_i(upred), .result_i(res), .branch_cnt_o(b0), .mispredict_cnt_o(m0)
    );

    bp_bht_predictor #(.ENTRIES(ENTRIES), .CTR_W(2), .GHR_W(4)) dut1 (
        .clk_i(clk), .rst_i(rst), .lookup_valid_i(lv), .lookup_pc_i(pc),
        .predict_o(p1), .predict_idx_o(i1), .update_i(upd), .update_idx_i(uidx),
        .update_pred_i(upred), .result_i(res), .branch_cnt_o(b1), .mispredict_cnt_o(m1)
    );

    bp_perf_counter #(.RST_VAL(32'hFFFF_FFFE)) u_sat (
        .clk_i(clk), .rst_i(sat_rst), .inc_i(sat_inc), .count_o(sat_cnt)
    );

    // ------------------------------------------------------------------
    // Reference model: plain integers, counter value 0..3, taken if >= 2.
    // ------------------------------------------------------------------
    int          m_tab0 [ENTRIES];
    int          m_tab1 [ENTRIES];
    int          m_ghr;
    logic [31:0] m_bcnt, m_mcnt;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        v;
        logic        p0, p1;
        logic [31:0] i0, i1;
        logic [31:0] bcnt, mcnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_txn   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < ENTRIES; k++) begin
            m_tab0[k] = 1;
            m_tab1[k] = 1;
        end
        m_ghr  = 0;
        m_bcnt = 32'h0;
        m_mcnt = 32'h0;
    endfunction

    function automatic int train(input int c, input bit taken);
        if (taken) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    // One cycle of stimulus: drive, queue expected outputs, advance model.
    task automatic txn(input bit r, input bit v, input logic [31:0] a, input bit u,
                       input int ui, input bit up, input bit rs);
        exp_t e;
        int   x0, x1;
        @(posedge clk);
        #2;
        rst = r; lv = v; pc = a; upd = u; uidx = IDX_W'(ui); upred = up; res = rs;
        x0     = (a / 4) % ENTRIES;
        x1     = x0 ^ m_ghr;
        e.id   = n_txn++;
        e.pc   = a;
        e.v    = v;
        e.i0   = 32'(x0);
        e.i1   = 32'(x1);
        e.p0   = v && (m_tab0[x0] >= 2);
        e.p1   = v && (m_tab1[x1] >= 2);
        e.bcnt = m_bcnt;
        e.mcnt = m_mcnt;
        exp_q.push_back(e);
        if (r) begin
            model_reset();
        end else if (u) begin
            m_tab0[ui] = train(m_tab0[ui], rs);
            m_tab1[ui] = train(m_tab1[ui], rs);
            m_ghr      = (m_ghr * 2 + (rs ? 1 : 0)) % 16;
            if (m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 32'd1;
            if ((up != rs) && (m_mcnt != 32'hFFFF_FFFF)) m_mcnt = m_mcnt + 32'd1;
        end
    endtask

    task automatic lookup(input logic [31:0] a);
        txn(1'b0, 1'b1, a, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic update(input int ui, input bit up, input bit rs);
        txn(1'b0, 1'b0, 32'h0, 1'b1, ui, up, rs);
    endtask

    task automatic do_reset();
        txn(1'b1, 1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("[TB] txn %0d pc=%h v=%0d pred=%0d/%0d idx=%0d/%0d bcnt=%0d mcnt=%0d",
                         e.id, e.pc, e.v, p0, p1, i0, i1, b0, m0);
                chk("predict_bimodal", 32'(p0), 32'(e.p0));
                chk("idx_bimodal",     32'(i0), e.i0);
                chk("predict_gshare",  32'(p1), 32'(e.p1));
                chk("idx_gshare",      32'(i1), e.i1);
                chk("branch_cnt",      b0, e.bcnt);
                chk("mispredict_cnt",  m0, e.mcnt);
                chk("branch_cnt_g",    b1, e.bcnt);
                chk("mispredict_cnt_g", m1, e.mcnt);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int ui, a;
        bit up, rs, v, u;

        model_reset();
        repeat (2) @(posedge clk);

        // Reset state and valid gating
        lookup(32'h0000_0010);
        txn(1'b0, 1'b0, 32'h0000_0010, 1'b0, 0, 1'b0, 1'b0);

        // Counter walk on idx 4
        update(4, 1'b0, 1'b1); lookup(32'h10);
        update(4, 1'b1, 1'b1); update(4, 1'b1, 1'b1); lookup(32'h10);
        update(4, 1'b1, 1'b0); lookup(32'h10);
        update(4, 1'b1, 1'b0); lookup(32'h10);
        update(4, 1'b0, 1'b0); update(4, 1'b0, 1'b0); lookup(32'h10);

        // Aliasing
        do_reset();
        update(4, 1'b0, 1'b1); update(4, 1'b0, 1'b1);
        lookup(32'h110); lookup(32'h14);

        // Same-cycle lookup and update on the same entry
        do_reset();
        txn(1'b0, 1'b1, 32'h10, 1'b1, 4, 1'b0, 1'b1);
        lookup(32'h10);

        // History build-up and perf counts: (1,1),(0,1),(0,0) on idx 0
        do_reset();
        update(0, 1'b1, 1'b1); update(0, 1'b0, 1'b1); update(0, 1'b0, 1'b0);
        lookup(32'h10);

        // Reset together with update: reset wins
        txn(1'b1, 1'b0, 32'h0, 1'b1, 4, 1'b0, 1'b1);
        lookup(32'h10);

        // Randomised traffic
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 1) == 1) a = int'($urandom_range(0, 255)) * 4;
            else                           a = int'($urandom);
            v  = ($urandom_range(0, 3) != 0);
            u  = ($urandom_range(0, 4) < 3);
            rs = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 1) ui = (a / 4) % ENTRIES;
            else                           ui = int'($urandom_range(0, ENTRIES - 1));
            if ($urandom_range(0, 1) == 1) up = (m_tab0[ui] >= 2);
            else                           up = ($urandom_range(0, 1) == 1);
            txn(($urandom_range(0, 49) == 0), v, a, u, ui, up, rs);
        end
        txn(1'b0, 1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0);

        // Drain the scoreboard
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end

        // Perf counter saturation
        @(posedge clk); #2;
        chk("sat_preload", sat_cnt, 32'hFFFF_FFFE);
        sat_rst = 1'b0;
        sat_inc = 1'b1;
        @(posedge clk); #2;
        chk("sat_reach", sat_cnt, 32'hFFFF_FFFF);
        @(posedge clk); #2;
        chk("sat_hold", sat_cnt, 32'hFFFF_FFFF);
        @(posedge clk); #2;
        chk("sat_hold2", sat_cnt, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_bht_predictor.md
# bp_bht_predictor

Parametrised branch-history-table predictor for the 5-stage RISC-V pipeline; successor to the single-counter branch predictor. It holds an array of saturating counters indexed by PC, or by PC XOR global history in gshare mode. It gives a taken/not-taken prediction for the branch being decoded in ID and trains on the resolved outcome from EX. It also keeps saturating performance counters for branches resolved and mispredictions.

## Interface
- ENTRIES, 64: number of counters; power of two, 2..1024; IDX_W = log2(ENTRIES).
- CTR_W, 2: counter width, 1..4.
- GHR_W, 0: global history length; 0 = bimodal, 1..IDX_W = gshare.
- clk_i  in  1  clock, the only clock.
- rst_i  in  1  reset; synchronous, active-high.
- lookup_valid_i  in  1  ID holds a branch to predict.
- lookup_pc_i  in  32  PC of the branch in ID.
- predict_o  out  1  predicted taken; 0 when lookup_valid_i = 0.
- predict_idx_o  out  IDX_W  table index used for this lookup; carried through ID/EX for the update.
- update_i  in  1  a branch resolved in EX this cycle.
- update_idx_i  in  IDX_W  index captured at lookup.
- update_pred_i  in  1  prediction that was made for this branch.
- result_i  in  1  actual outcome (1 = taken).
- branch_cnt_o  out  32  branches resolved.
- mispredict_cnt_o  out  32  mispredictions.

## Operation
- Index = lookup_pc_i[IDX_W+1:2] XOR {zero-pad, ghr}. When GHR_W = 0, the XOR term is 0.
- predict_o = lookup_valid_i & table[index][CTR_W-1], the counter MSB.
- Counter init value INIT = 2^(CTR_W-1) - 1 (weakly not-taken). With CTR_W = 2 this is 01; with CTR_W = 1 it is 0.
- On update_i, table[update_idx_i] changes as follows:
  - result_i = 1: counter saturates upward at all-ones.
  - result_i = 0: counter saturates downward at 0.
- On update_i, ghr <= {ghr[GHR_W-2:0], result_i}. History is non-speculative and is updated only at resolution.
- On update_i, branch_cnt_o increments by 1. mispredict_cnt_o increments by 1 when update_pred_i != result_i. Both hold at 32'hFFFF_FFFF and do not wrap.
- Lookup and update are independent. Both may occur in the same cycle, on the same or different indices.
- Same-cycle update and lookup to the same index: predict_o shows the pre-update counter (read-before-write). There is no bypass.
- update_idx_i is used verbatim. The predictor does not recompute the index from PC, so a GHR change between lookup and update cannot mistrain another entry.

## Timing
- Prediction path is combinational, lookup_pc_i/state to predict_o/predict_idx_o, with zero latency, for use in ID in the same cycle.
- Update latency is 1 cycle. Table, ghr and perf counters change at the edge where update_i = 1 and are visible from the following cycle.
- Reset is synchronous. On the edge with rst_i = 1:
  - every table entry goes to INIT;
  - ghr goes to 0;
  - branch_cnt_o and mispredict_cnt_o go to 0.
- Reset values at the outputs: predict_o = 0 for any PC, predict_idx_o = lookup_pc_i[IDX_W+1:2], both counts 0.
- rst_i and update_i in the same cycle: reset wins and the update is dropped.
- There is no handshake and no stall. The predictor accepts one update every cycle.

## Structure
- Package bp_pkg holds:
  - function sat_inc(ctr, w) and function sat_dec(ctr, w);
  - function ctr_init(w);
  - constant IDX_W derivation helper (clog2 wrapper).
- Table: a flop array of ENTRIES x CTR_W with a reset loop. No SRAM, because reset must clear every entry in one cycle.
- One sub-module: bp_perf_counter, a 32-bit saturating event counter with inc_i, instantiated twice.

## Test plan
Defaults ENTRIES=64, CTR_W=2, GHR_W=0 unless stated.
- Reset, then lookup pc 0x0000_0010 with valid=1 -> predict_o=0, predict_idx_o=4, both counts 0. Same lookup with valid=0 -> predict_o=0.
- Updates to idx 4: T -> next cycle predict_o=1 (ctr 10). T, T -> ctr 11, saturated. N -> 10, still predicts 1. N -> 01, predicts 0. N, N -> 00, saturated.
- Aliasing: train pc 0x10 taken twice -> lookup pc 0x110 (idx 4) -> predict_o=1. Lookup pc 0x14 (idx 5) -> predict_o=0.
- Same-cycle lookup of 0x10 and taken update of idx 4 from ctr 01 -> predict_o=0 that cycle, 1 the next.
- GHR_W=4: resolve T, T, N on idx 0 -> ghr=4'b0110. Lookup pc 0x10 -> predict_idx_o=2.
- Perf and reset:
  - Three updates with pred/result pairs (1,1), (0,1), (0,0) -> branch_cnt_o=3, mispredict_cnt_o=1.
  - Force branch_cnt_o to 32'hFFFF_FFFF, then update -> stays FFFF_FFFF.
  - rst_i=1 together with update_i=1 -> counts 0, table at INIT, ghr 0 on the next cycle.
